// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 cache controller.
// Read hits answer combinationally; misses and all writes stall via busy until memory answers.
module l1_cache_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int IDX_W  = 2,
  parameter int OFF_W  = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cpu_read,
  input  logic                           cpu_write,
  input  logic [ADDR_W-1:0]              cpu_address,
  input  logic [WORD_W-1:0]              cpu_wdata,
  output logic [WORD_W-1:0]              cpu_rdata,
  output logic                           busy,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [WORD_W-1:0]              mem_wdata,
  input  logic [WORD_W*(2**OFF_W)-1:0]   mem_rdata,
  input  logic                           mem_ready,
  output logic [15:0]                    access_count,
  output logic [15:0]                    hit_count
);

  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int LINES = 2**IDX_W;
  localparam int WORDS = 2**OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [WORD_W-1:0] r_data [LINES][WORDS];

  logic              r_refilled;
  logic              r_wr_hit;
  logic [ADDR_W-1:0] r_mem_address;
  logic [WORD_W-1:0] r_mem_wdata;
  logic [15:0]       r_access;
  logic [15:0]       r_hits;

  logic [TAG_W-1:0]  w_cpu_tag;
  logic [IDX_W-1:0]  w_cpu_idx;
  logic [OFF_W-1:0]  w_cpu_off;
  logic [TAG_W-1:0]  w_mem_tag;
  logic [IDX_W-1:0]  w_mem_idx;
  logic [OFF_W-1:0]  w_mem_off;
  logic              w_hit;
  logic              w_mem_hit;
  logic              w_busy;
  logic              w_done;
  logic              w_first_hit;

  assign w_cpu_tag = cpu_address[ADDR_W-1 -: TAG_W];
  assign w_cpu_idx = cpu_address[OFF_W +: IDX_W];
  assign w_cpu_off = cpu_address[OFF_W-1:0];
  assign w_mem_tag = r_mem_address[ADDR_W-1 -: TAG_W];
  assign w_mem_idx = r_mem_address[OFF_W +: IDX_W];
  assign w_mem_off = r_mem_address[OFF_W-1:0];

  assign w_hit     = r_valid[w_cpu_idx] && (r_tag[w_cpu_idx] == w_cpu_tag);
  assign w_mem_hit = r_valid[w_mem_idx] && (r_tag[w_mem_idx] == w_mem_tag);

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = (cpu_read && !w_hit) || cpu_write;
        if (cpu_write)                w_next = ST_WRITE;
        else if (cpu_read && !w_hit)  w_next = ST_FILL;
      end
      ST_FILL: begin
        w_busy = 1'b1;
        if (mem_ready) w_next = ST_IDLE;
      end
      ST_WRITE: begin
        w_busy = !mem_ready;
        if (mem_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_done = (cpu_read || cpu_write) && !w_busy;
  // IDLE completes only read hits; a write's hit status was captured when it left IDLE.
  assign w_first_hit = (r_state == ST_IDLE) ? !r_refilled
                                            : ((r_state == ST_WRITE) && r_wr_hit);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_valid       <= '0;
      r_refilled    <= 1'b0;
      r_wr_hit      <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_access      <= '0;
      r_hits        <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) begin
        if (cpu_write) begin
          r_mem_address <= cpu_address;
          r_mem_wdata   <= cpu_wdata;
          r_wr_hit      <= w_hit && !r_refilled;
        end else if (cpu_read && !w_hit) begin
          r_mem_address <= {cpu_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
      end
      if (r_state == ST_FILL && mem_ready) begin
        r_valid[w_mem_idx] <= 1'b1;
        r_refilled         <= 1'b1;
      end
      if (w_done) begin
        r_refilled <= 1'b0;
        if (r_access != '1)               r_access <= r_access + 16'd1;
        if (w_first_hit && r_hits != '1)  r_hits   <= r_hits + 16'd1;
      end
    end
  end

  // Line contents need no reset; validity alone gates their use.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_state == ST_FILL && mem_ready) begin
        r_tag[w_mem_idx] <= w_mem_tag;
        for (int unsigned w = 0; w < WORDS; w++)
          r_data[w_mem_idx][w[OFF_W-1:0]] <= mem_rdata[w*WORD_W +: WORD_W];
      end else if (r_state == ST_WRITE && mem_ready && w_mem_hit) begin
        r_data[w_mem_idx][w_mem_off] <= r_mem_wdata;
      end
    end
  end

  assign cpu_rdata    = r_data[w_cpu_idx][w_cpu_off];
  assign busy         = w_busy;
  assign mem_read     = (r_state == ST_FILL);
  assign mem_write    = (r_state == ST_WRITE);
  assign mem_address  = r_mem_address;
  assign mem_wdata    = r_mem_wdata;
  assign access_count = r_access;
  assign hit_count    = r_hits;

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Self-checking bench for l1_cache_ctrl: directed vector table, reset/abort sequences,
// and random traffic scored against a line-level cache model with a backing memory array.
module tb_l1_cache_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        busy;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] access_count;
  logic [15:0] hit_count;

  l1_cache_ctrl #(.ADDR_W(16), .WORD_W(16), .IDX_W(2), .OFF_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .access_count(access_count), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] bmem [65536];
  int          g_lat = 0;
  int          g_spur_req = 0;
  int          g_spur_done = 0;
  logic [15:0] g_last_maddr;
  logic [15:0] g_last_wdata;

  // Backing memory: answers g_lat cycles after a request first appears.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    g_last_maddr = '0;
    g_last_wdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        if (cnt == g_lat) begin
          mem_ready    = 1'b1;
          g_last_maddr = mem_address;
          g_last_wdata = mem_wdata;
          if (mem_read)
            mem_rdata = {bmem[16'(mem_address + 16'd3)], bmem[16'(mem_address + 16'd2)],
                         bmem[16'(mem_address + 16'd1)], bmem[mem_address]};
          else
            bmem[mem_address] = mem_wdata;
        end
        cnt++;
      end else begin
        cnt = 0;
        if (g_spur_req != g_spur_done) begin
          mem_ready = 1'b1;
          g_spur_done++;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Entered just after a rising edge; presents one request and holds it until busy drops.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int lat, input int exp_busy,
                        input logic chk_data, input logic [15:0] exp_data,
                        input logic chk_mem, input logic [15:0] exp_maddr,
                        input int exp_acc, input int exp_hit);
    int          nb;
    bit          done;
    logic [15:0] got;
    g_lat = lat;
    cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_wdata = d;
    nb = 0; done = 1'b0; got = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
        got  = cpu_rdata;
      end
    end
    chk("complete", 32'(done), 32'd1);
    chk("busy_cycles", 32'(nb), 32'(exp_busy));
    if (chk_data) chk("rdata", 32'(got), 32'(exp_data));
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    chk("access_count", 32'(access_count), 32'(exp_acc));
    chk("hit_count", 32'(hit_count), 32'(exp_hit));
    if (chk_mem) begin
      chk("mem_address", 32'(g_last_maddr), 32'(exp_maddr));
      if (wr) chk("mem_wdata", 32'(g_last_wdata), 32'(d));
    end
  endtask

  // Behavioural cache model: per-line valid/tag/words plus event counts.
  logic        m_valid [4];
  logic [11:0] m_tag   [4];
  logic [15:0] m_line  [4][4];
  int          m_acc;
  int          m_hits;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_acc = 0;
    m_hits = 0;
  endtask

  task automatic model_req(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, input int lat);
    logic [1:0]  idx;
    logic [1:0]  off;
    logic [15:0] base;
    logic        hit;
    idx  = a[3:2];
    off  = a[1:0];
    base = {a[15:2], 2'b00};
    hit  = m_valid[idx] && (m_tag[idx] == a[15:4]);
    m_acc++;
    if (wr) begin
      if (hit) begin
        m_line[idx][off] = d;
        m_hits++;
      end
      do_req(rd, wr, a, d, lat, lat + 1, 1'b0, '0, 1'b1, a, m_acc, m_hits);
    end else if (hit) begin
      m_hits++;
      do_req(1'b1, 1'b0, a, d, lat, 0, 1'b1, m_line[idx][off], 1'b0, '0, m_acc, m_hits);
    end else begin
      for (int k = 0; k < 4; k++) m_line[idx][k] = bmem[16'(base + 16'(k))];
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[15:4];
      do_req(1'b1, 1'b0, a, d, lat, lat + 2, 1'b1, m_line[idx][off], 1'b1, base,
             m_acc, m_hits);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          busy_cyc;
    logic        chk_data;
    logic [15:0] data;
    logic        chk_mem;
    logic [15:0] maddr;
    int          acc;
    int          hit;
  } vec_t;

  vec_t vecs [11];

  initial begin
    for (int i = 0; i < 65536; i++) bmem[i] = 16'((i * 40503) ^ 23130);
    bmem[16'h0120] = 16'h1111; bmem[16'h0121] = 16'h2222;
    bmem[16'h0122] = 16'h3333; bmem[16'h0123] = 16'h4444;
    bmem[16'h1120] = 16'hA000; bmem[16'h1121] = 16'hA001;
    bmem[16'h1122] = 16'hA002; bmem[16'h1123] = 16'hA003;
    bmem[16'h2000] = 16'hC000;

    //           rd    wr    addr      wdata     lat busy chkd  data      chkm  maddr   acc hit
    vecs[0]  = '{1'b1, 1'b0, 16'h0123, 16'h0000, 3, 5, 1'b1, 16'h4444, 1'b1, 16'h0120, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0121, 16'h0000, 3, 0, 1'b1, 16'h2222, 1'b0, 16'h0000, 2, 1};
    vecs[2]  = '{1'b1, 1'b0, 16'h1120, 16'h0000, 3, 5, 1'b1, 16'hA000, 1'b1, 16'h1120, 3, 1};
    vecs[3]  = '{1'b1, 1'b0, 16'h0123, 16'h0000, 3, 5, 1'b1, 16'h4444, 1'b1, 16'h0120, 4, 1};
    vecs[4]  = '{1'b0, 1'b1, 16'h0122, 16'hBEEF, 2, 3, 1'b0, 16'h0000, 1'b1, 16'h0122, 5, 2};
    vecs[5]  = '{1'b1, 1'b0, 16'h0122, 16'h0000, 2, 0, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 6, 3};
    vecs[6]  = '{1'b1, 1'b1, 16'h0121, 16'h7777, 1, 2, 1'b0, 16'h0000, 1'b1, 16'h0121, 7, 4};
    vecs[7]  = '{1'b1, 1'b0, 16'h0121, 16'h0000, 1, 0, 1'b1, 16'h7777, 1'b0, 16'h0000, 8, 5};
    vecs[8]  = '{1'b0, 1'b1, 16'h2000, 16'h1234, 2, 3, 1'b0, 16'h0000, 1'b1, 16'h2000, 9, 5};
    vecs[9]  = '{1'b1, 1'b0, 16'h0123, 16'h0000, 2, 0, 1'b1, 16'h4444, 1'b0, 16'h0000, 10, 6};
    vecs[10] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 1, 3, 1'b1, 16'h1234, 1'b1, 16'h2000, 11, 6};

    reset_n = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0;

    // Reset state after two reset edges.
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_access", 32'(access_count), 32'd0);
    chk("rst_hit", 32'(hit_count), 32'd0);
    reset_n = 1'b1;

    // A stray mem_ready while idle must not disturb anything.
    g_spur_req++;
    repeat (2) begin @(posedge clk); #1; end
    chk("spur_mem_read", 32'(mem_read), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_access", 32'(access_count), 32'd0);

    for (int v = 0; v < 11; v++)
      do_req(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].lat,
             vecs[v].busy_cyc, vecs[v].chk_data, vecs[v].data, vecs[v].chk_mem,
             vecs[v].maddr, vecs[v].acc, vecs[v].hit);

    // Reset in the middle of a fill that memory never answers.
    g_lat = 1000;
    cpu_read = 1'b1; cpu_address = 16'h3006;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_mem_read_before", 32'(mem_read), 32'd1);
    chk("abort_mem_address", 32'(mem_address), 32'h3004);
    reset_n = 1'b0;
    cpu_read = 1'b0;
    @(posedge clk); #1;
    chk("abort_mem_read_after", 32'(mem_read), 32'd0);
    chk("abort_access", 32'(access_count), 32'd0);
    reset_n = 1'b1;
    model_reset();
    model_req(1'b1, 1'b0, 16'h3006, 16'h0000, 2);

    // Random traffic over three tags so lines both hit and conflict.
    for (int t = 0; t < 250; t++) begin
      int          k;
      int          lat;
      logic [15:0] a;
      logic [15:0] d;
      k   = $urandom_range(0, 9);
      lat = $urandom_range(0, 4);
      a   = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
      d   = 16'($urandom);
      if (k <= 5)      model_req(1'b1, 1'b0, a, d, lat);
      else if (k <= 8) model_req(1'b0, 1'b1, a, d, lat);
      else             model_req(1'b1, 1'b1, a, d, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_cache_ctrl.md
# l1_cache_ctrl

Direct-mapped, write-through, no-write-allocate L1 cache controller between a pipeline memory port and slow backing memory. Two instances are used: one on the instruction port and one on the data port. The instance's `busy` output drives the hazard unit's `M1busy` (instruction) or `M2busy` (data) input, which converts it into IF/ID/MEM stalls. Read hits return data combinationally with no stall. Misses and all writes hold `busy` until backing memory answers.

## Interface
Parameters:
- `ADDR_W`, 16: word address width.
- `WORD_W`, 16: data word width.
- `IDX_W`, 2: index bits (4 lines).
- `OFF_W`, 2: word-offset bits (4 words per line). Tag width is `ADDR_W-IDX_W-OFF_W` (12 bits).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `cpu_read`  in  1  read request; held by the pipeline while stalled.
- `cpu_write`  in  1  write request; held by the pipeline while stalled.
- `cpu_address`  in  ADDR_W  word address.
- `cpu_wdata`  in  WORD_W  write data.
- `cpu_rdata`  out  WORD_W  read data; valid when `cpu_read && !busy`.
- `busy`  out  1  request not yet complete; the pipeline must hold the request.
- `mem_read`  out  1  line-fill request.
- `mem_write`  out  1  single-word write-through request.
- `mem_address`  out  ADDR_W  fills: line-aligned (offset bits 0); writes: word address.
- `mem_wdata`  out  WORD_W  write-through data.
- `mem_rdata`  in  4*WORD_W  fill line; word 0 in bits [15:0].
- `mem_ready`  in  1  one-cycle completion pulse from memory.
- `access_count`  out  16  completed requests, saturating.
- `hit_count`  out  16  requests that hit on first evaluation, saturating.

## Operation
- Storage per line: valid bit, tag, 4 words. `hit = valid[idx] && tag[idx]==cpu_address tag`.
- FSM states and transitions:
  - IDLE:
    - `cpu_write` → WRITE, whether hit or miss.
    - `cpu_read` && !hit → FILL.
    - `cpu_read` && hit → stay in IDLE; request completes this cycle.
  - FILL: `mem_read`=1, address = line-aligned request address. On `mem_ready`: write the whole line, set valid and tag, set `refilled`, go to IDLE.
  - WRITE: `mem_write`=1 with request address and data. On `mem_ready`: if hit, update the cached word; go to IDLE. A write miss leaves the cache unchanged.
- `busy`:
  - IDLE: `(cpu_read && !hit) || cpu_write`.
  - FILL: 1.
  - WRITE: `!mem_ready`.
- `cpu_read` and `cpu_write` asserted together: treated as a write.
- `mem_ready` in IDLE is ignored.
- `mem_address` and `mem_wdata` are latched at IDLE exit and stable while the request is outstanding.
- Counters:
  - `access_count` increments on every cycle with `(cpu_read||cpu_write) && !busy`.
  - `hit_count` increments on the completing cycle only when the hit was found on first IDLE evaluation. A read completing right after FILL (`refilled`=1) is not a hit. `refilled` clears on completion.
  - Both counters saturate at 0xFFFF.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE, all valid bits 0, `refilled`=0, both counters 0, `mem_read`=`mem_write`=0, `mem_address`=`mem_wdata`=0. `busy` then follows the IDLE equation.
- Reset mid-FILL or mid-WRITE: aborts immediately, without waiting for `mem_ready`; the partial line is discarded.
- Read hit: 0 stall cycles.
- Read miss requested in cycle C:
  - `busy`=1 in C.
  - `mem_read`=1 from C+1 through the `mem_ready` cycle R.
  - IDLE at R+1: hit, `busy`=0, data valid. Total stall = R−C+1 cycles.
- Write requested in cycle C:
  - `mem_write`=1 from C+1 through R.
  - `busy`=0 in R; the pipeline advances at the edge ending R.
- Back-to-back: a new request presented in the cycle after completion is evaluated normally. No idle bubble is inserted.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `cpu_read`=0 → `busy`=0, `mem_read`=`mem_write`=0, both counters 0.
- Cold read miss at 0x0123, `mem_ready` pulsed 3 cycles after `mem_read` rises, `mem_rdata`=0x4444_3333_2222_1111:
  - `mem_address`=0x0120 during the fill.
  - `busy` high for 5 cycles.
  - `cpu_rdata`=0x4444 on completion.
  - access=1, hit=0.
- Then read 0x0121 → `busy`=0 same cycle, `cpu_rdata`=0x2222, access=2, hit=1.
- Conflict miss: read 0x1120 after the 0x0120 line is loaded → FILL at 0x1120. Then re-read 0x0123 → misses again.
- Write hit at 0x0122 with data 0xBEEF, `mem_ready` after 2 cycles:
  - `mem_write`=1, `mem_address`=0x0122, `mem_wdata`=0xBEEF.
  - `busy` drops in the `mem_ready` cycle.
  - A following read of 0x0122 returns 0xBEEF with no stall.
- Write miss at 0x2000: cache unchanged, and a read of 0x2000 still misses. Separately, assert `reset_n`=0 mid-FILL → `mem_read` drops next cycle and a re-read of the same address misses.
